// File: rtl/stack_controller.sv
// stack_controller: push/pop sequencer for a counter-pointer stack.
// Drives the up/down pointer counter and a single-port synchronous RAM.
module stack_controller #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  ClrN,
  input  logic                  Push,
  input  logic                  Pop,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  DataValid,
  output logic                  Ready,
  output logic                  Full,
  output logic                  Empty,
  output logic                  Overflow,
  output logic                  Underflow,
  output logic                  Conflict,
  input  logic [ADDR_WIDTH:0]   SpIn,
  output logic                  CntEn,
  output logic                  CntD,
  output logic                  CntClrN,
  output logic [ADDR_WIDTH-1:0] RamAddr,
  output logic                  RamWe,
  output logic [DATA_WIDTH-1:0] RamWrData,
  input  logic [DATA_WIDTH-1:0] RamRdData
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_DEC   = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  localparam logic [ADDR_WIDTH:0] SP_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] SP_ZERO = '0;

  logic [2:0]            state_q, state_d;
  logic                  run_q;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  cfl_q, cfl_d;
  logic                  clrn_q;

  assign Full  = (SpIn == SP_FULL);
  assign Empty = (SpIn == SP_ZERO);
  assign Ready = run_q && (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    cfl_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Ready) begin
          priority case (1'b1)
            Push && Pop:  cfl_d = 1'b1;
            Push && Full: ovf_d = 1'b1;
            Push: begin
              word_d  = DataIn;
              state_d = S_WRITE;
            end
            Pop && Empty: unf_d = 1'b1;
            Pop:          state_d = S_DEC;
            default: ;
          endcase
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_DEC:   state_d = S_READ;
      S_READ:  state_d = S_WAIT;
      S_WAIT: begin
        dout_d  = RamRdData;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // address always follows the pointer; only WRITE and READ make it matter
  assign RamAddr   = SpIn[ADDR_WIDTH-1:0];
  assign RamWe     = (state_q == S_WRITE);
  assign RamWrData = word_q;
  assign CntEn     = (state_q == S_WRITE) || (state_q == S_DEC);
  assign CntD      = (state_q == S_DEC);
  assign CntClrN   = clrn_q;
  assign DataOut   = dout_q;
  assign DataValid = valid_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;
  assign Conflict  = cfl_q;

  always_ff @(posedge Clk) begin
    clrn_q <= ClrN;
    if (!ClrN) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
      word_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      cfl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      word_q  <= word_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      cfl_q   <= cfl_d;
    end
  end

endmodule

// File: tb/tb_stack_controller.sv
// tb_stack_controller: stack_controller with counter/RAM models,
// table vectors, corner sequences and a queue-based random run.
module tb_stack_controller;

  localparam int AW  = 2;
  localparam int DW  = 8;
  localparam int CAP = 4;

  logic          Clk, ClrN, Push, Pop;
  logic [DW-1:0] DataIn, DataOut, RamWrData, RamRdData;
  logic          DataValid, Ready, Full, Empty;
  logic          Overflow, Underflow, Conflict;
  logic [AW:0]   SpIn;
  logic          CntEn, CntD, CntClrN, RamWe;
  logic [AW-1:0] RamAddr;

  stack_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .Clk(Clk), .ClrN(ClrN), .Push(Push), .Pop(Pop),
    .DataIn(DataIn), .DataOut(DataOut), .DataValid(DataValid),
    .Ready(Ready), .Full(Full), .Empty(Empty),
    .Overflow(Overflow), .Underflow(Underflow), .Conflict(Conflict),
    .SpIn(SpIn), .CntEn(CntEn), .CntD(CntD), .CntClrN(CntClrN),
    .RamAddr(RamAddr), .RamWe(RamWe), .RamWrData(RamWrData),
    .RamRdData(RamRdData)
  );

  // pointer counter and RAM the controller sits between
  logic [DW-1:0] mem [CAP];
  always @(posedge Clk) begin
    if (!CntClrN) SpIn <= '0;
    else if (CntEn) SpIn <= CntD ? SpIn - 3'd1 : SpIn + 3'd1;
  end
  always @(posedge Clk) begin
    if (RamWe) mem[RamAddr] <= RamWrData;
    RamRdData <= mem[RamAddr];
  end

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] last_out;

  typedef struct {
    logic          pu;
    logic          po;
    logic [DW-1:0] d;
    logic [AW:0]   exp_sp;
    logic [DW-1:0] exp_dout;
  } vec_t;
  vec_t tbl[20];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic op(input logic pu, input logic po, input logic [DW-1:0] d);
    int n;
    logic [DW-1:0] e;
    logic [2:0] exp_err;
    n = q.size();
    chk("ready_start", 32'(Ready), 32'd1);
    chk("full", 32'(Full), 32'(n == CAP));
    chk("empty", 32'(Empty), 32'(n == 0));
    exp_err = 3'b000;
    if (pu && po) exp_err = 3'b100;
    else if (pu && n == CAP) exp_err = 3'b010;
    else if (po && !pu && n == 0) exp_err = 3'b001;
    Push = pu; Pop = po; DataIn = d;
    step();
    Push = 1'b0; Pop = 1'b0;
    chk("err_pulse", 32'({Conflict, Overflow, Underflow}), 32'(exp_err));
    if (exp_err != 3'b000) begin
      chk("err_cnten", 32'(CntEn), 32'd0);
      chk("err_we", 32'(RamWe), 32'd0);
      chk("err_ready", 32'(Ready), 32'd1);
      step();
      chk("pulse_len", 32'({Conflict, Overflow, Underflow}), 32'd0);
    end else if (pu) begin
      chk("wr_we", 32'(RamWe), 32'd1);
      chk("wr_cnt", 32'({CntEn, CntD}), 32'b10);
      chk("wr_data", 32'(RamWrData), 32'(d));
      chk("wr_addr", 32'(RamAddr), 32'(n % CAP));
      chk("wr_ready", 32'(Ready), 32'd0);
      q.push_back(d);
      step();
    end else if (po) begin
      e = q.pop_back();
      chk("dec_cnt", 32'({CntEn, CntD}), 32'b11);
      chk("dec_ready", 32'(Ready), 32'd0);
      step();
      chk("rd_addr", 32'(RamAddr), 32'(n - 1));
      chk("rd_ctl", 32'({CntEn, RamWe, DataValid}), 32'd0);
      step();
      chk("wait_valid", 32'(DataValid), 32'd0);
      step();
      chk("pop_valid", 32'(DataValid), 32'd1);
      chk("pop_data", 32'(DataOut), 32'(e));
      last_out = e;
    end
    chk("sp", 32'(SpIn), 32'(q.size()));
    chk("dout_hold", 32'(DataOut), 32'(last_out));
    chk("ready_end", 32'(Ready), 32'd1);
  endtask

  initial begin
    logic [2:0] err;
    int nv;
    logic [DW-1:0] vals[4];
    int r;

    tbl[0]  = '{1'b0, 1'b1, 8'h00, 3'd0, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 8'h11, 3'd1, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 8'h22, 3'd2, 8'h00};
    tbl[3]  = '{1'b1, 1'b0, 8'h33, 3'd3, 8'h00};
    tbl[4]  = '{1'b0, 1'b1, 8'h00, 3'd2, 8'h33};
    tbl[5]  = '{1'b0, 1'b1, 8'h00, 3'd1, 8'h22};
    tbl[6]  = '{1'b0, 1'b1, 8'h00, 3'd0, 8'h11};
    tbl[7]  = '{1'b1, 1'b0, 8'hA1, 3'd1, 8'h11};
    tbl[8]  = '{1'b1, 1'b0, 8'hA2, 3'd2, 8'h11};
    tbl[9]  = '{1'b1, 1'b1, 8'hEE, 3'd2, 8'h11};
    tbl[10] = '{1'b1, 1'b0, 8'hA3, 3'd3, 8'h11};
    tbl[11] = '{1'b1, 1'b0, 8'hA4, 3'd4, 8'h11};
    tbl[12] = '{1'b1, 1'b0, 8'hA5, 3'd4, 8'h11};
    tbl[13] = '{1'b0, 1'b1, 8'h00, 3'd3, 8'hA4};
    tbl[14] = '{1'b1, 1'b0, 8'hB5, 3'd4, 8'hA4};
    tbl[15] = '{1'b0, 1'b1, 8'h00, 3'd3, 8'hB5};
    tbl[16] = '{1'b0, 1'b1, 8'h00, 3'd2, 8'hA3};
    tbl[17] = '{1'b0, 1'b1, 8'h00, 3'd1, 8'hA2};
    tbl[18] = '{1'b0, 1'b1, 8'h00, 3'd0, 8'hA1};
    tbl[19] = '{1'b0, 1'b1, 8'h00, 3'd0, 8'hA1};

    ClrN = 1'b0; Push = 1'b0; Pop = 1'b0; DataIn = '0;
    last_out = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ready", 32'(Ready), 32'd0);
      chk("rst_outs", 32'({DataValid, Overflow, Underflow, Conflict,
                           CntEn, RamWe, CntClrN}), 32'd0);
      chk("rst_dout", 32'(DataOut), 32'd0);
    end
    ClrN = 1'b1;
    step();
    chk("rel_ready", 32'(Ready), 32'd1);
    chk("rel_sp", 32'(SpIn), 32'd0);
    chk("rel_flags", 32'({Empty, Full}), 32'b10);
    chk("rel_cntclrn", 32'(CntClrN), 32'd1);

    for (int i = 0; i < 20; i++) begin
      op(tbl[i].pu, tbl[i].po, tbl[i].d);
      chk("tbl_sp", 32'(SpIn), 32'(tbl[i].exp_sp));
      chk("tbl_dout", 32'(DataOut), 32'(tbl[i].exp_dout));
    end

    // requests held high across busy cycles
    err = 3'b000;
    Push = 1'b1;
    for (int k = 0; k < 4; k++) begin
      DataIn = 8'hC0 + 8'(k);
      step();
      err |= {Conflict, Overflow, Underflow};
    end
    Push = 1'b0;
    q.push_back(8'hC0);
    q.push_back(8'hC2);
    chk("held_push_sp", 32'(SpIn), 32'd2);
    nv = 0;
    Pop = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      err |= {Conflict, Overflow, Underflow};
      if (DataValid && nv < 4) begin
        vals[nv] = DataOut;
        nv++;
      end
    end
    Pop = 1'b0;
    chk("held_err", 32'(err), 32'd0);
    chk("held_nvalid", 32'(nv), 32'd2);
    chk("held_v0", 32'(vals[0]), 32'hC2);
    chk("held_v1", 32'(vals[1]), 32'hC0);
    chk("held_pop_sp", 32'(SpIn), 32'd0);
    void'(q.pop_back());
    void'(q.pop_back());
    last_out = 8'hC0;

    // reset while in READ
    op(1'b1, 1'b0, 8'h5A);
    op(1'b1, 1'b0, 8'h6B);
    Pop = 1'b1;
    step();
    Pop = 1'b0;
    step();
    chk("rr_addr", 32'(RamAddr), 32'd1);
    ClrN = 1'b0;
    nv = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (DataValid) nv++;
      chk("rr_ctl", 32'({Ready, CntEn, RamWe, CntClrN}), 32'd0);
    end
    ClrN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (DataValid) nv++;
    end
    chk("rr_novalid", 32'(nv), 32'd0);
    chk("rr_sp", 32'(SpIn), 32'd0);
    chk("rr_dout", 32'(DataOut), 32'd0);
    q.delete();
    last_out = '0;

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) op(1'b1, 1'b1, 8'($urandom));
      else if (r < 5) op(1'b1, 1'b0, 8'($urandom));
      else if (r < 9) op(1'b0, 1'b1, 8'h00);
      else op(1'b0, 1'b0, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
